// File: rtl/warp_scheduler_if.sv
// Control bundle between the warp scheduler and the rest of the core: launch,
// fetch/decode/LSU status in; FSM state, active warp and retirement status out.
interface warp_scheduler_if #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 4,
    parameter int WID_W            = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) ();
    logic                          start;
    logic [WID_W:0]                num_warps;
    logic                          request_ready;
    logic                          decoded_ret;
    logic [2*THREADS_PER_WARP-1:0] lsu_state;
    logic [3:0]                    core_state;
    logic [WID_W-1:0]              active_warp;
    logic                          update_en;
    logic [NUM_WARPS-1:0]          warp_done;
    logic                          done;
    logic [15:0]                   wait_cycles;

    modport master (
        output start, num_warps, request_ready, decoded_ret, lsu_state,
        input  core_state, active_warp, update_en, warp_done, done, wait_cycles
    );

    modport slave (
        input  start, num_warps, request_ready, decoded_ret, lsu_state,
        output core_state, active_warp, update_en, warp_done, done, wait_cycles
    );
endinterface

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: picks one eligible warp per instruction and steps
// it through fetch, decode, issue, LSU request/wait, execute and PC update.
module warp_scheduler #(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 4,
    parameter int WID_W            = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    warp_scheduler_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE    = 4'b0000,
        FETCH   = 4'b0001,
        DECODE  = 4'b0010,
        ISSUE   = 4'b0011,
        REQUEST = 4'b0100,
        WAIT    = 4'b0101,
        EXECUTE = 4'b0110,
        UPDATE  = 4'b0111,
        DONE    = 4'b1000,
        SELECT  = 4'b1001
    } state_t;

    localparam logic [WID_W:0]   MAX_COUNT = NUM_WARPS[WID_W:0];
    localparam logic [WID_W-1:0] PTR_INIT  = WID_W'(NUM_WARPS - 1);

    state_t               state;
    logic [WID_W-1:0]     active_warp;
    logic [WID_W-1:0]     ptr;
    logic [NUM_WARPS-1:0] warp_done;
    logic                 done;
    logic [15:0]          wait_cycles;
    logic [WID_W:0]       count;

    logic                 lsu_busy;
    logic                 sel_found;
    logic [WID_W-1:0]     sel_idx;
    logic [WID_W-1:0]     cand_idx;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [WID_W:0] clamp_count(input logic [WID_W:0] n);
        return (n > MAX_COUNT) ? MAX_COUNT : n;
    endfunction

    // Only REQUESTING (01) and WAITING (10) hold the warp in WAIT.
    always_comb begin
        lsu_busy = 1'b0;
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
            if (bus.lsu_state[2*t +: 2] == 2'b01 || bus.lsu_state[2*t +: 2] == 2'b10)
                lsu_busy = 1'b1;
        end
    end

    // Search starts one past the last-run warp so a warp that just ran goes last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand_idx  = ptr;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            cand_idx = WID_W'((int'(ptr) + i) % NUM_WARPS);
            if (!sel_found && ({1'b0, cand_idx} < count) && !warp_done[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            active_warp <= '0;
            ptr         <= PTR_INIT;
            warp_done   <= '0;
            done        <= 1'b0;
            wait_cycles <= '0;
            count       <= '0;
        end else begin
            if (state == WAIT)
                wait_cycles <= sat_inc16(wait_cycles);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count       <= clamp_count(bus.num_warps);
                        warp_done   <= '0;
                        wait_cycles <= '0;
                        ptr         <= PTR_INIT;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        active_warp <= sel_idx;
                        ptr         <= sel_idx;
                        state       <= FETCH;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                FETCH:   if (bus.request_ready) state <= DECODE;
                DECODE:  state <= ISSUE;
                ISSUE:   state <= REQUEST;
                REQUEST: state <= WAIT;
                WAIT:    if (!lsu_busy) state <= EXECUTE;
                EXECUTE: state <= UPDATE;
                UPDATE: begin
                    if (bus.decoded_ret)
                        warp_done[active_warp] <= 1'b1;
                    state <= SELECT;
                end
                DONE:    done <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.core_state  = state;
    assign bus.active_warp = active_warp;
    assign bus.update_en   = (state == UPDATE);
    assign bus.warp_done   = warp_done;
    assign bus.done        = done;
    assign bus.wait_cycles = wait_cycles;
endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: expected warp order is queued at launch and
// compared against active_warp on every update_en pulse.
module tb_warp_scheduler;
    localparam int NW  = 4;
    localparam int TPW = 4;
    localparam int WW  = 2;

    localparam logic [3:0] S_IDLE    = 4'b0000;
    localparam logic [3:0] S_FETCH   = 4'b0001;
    localparam logic [3:0] S_REQUEST = 4'b0100;
    localparam logic [3:0] S_WAIT    = 4'b0101;
    localparam logic [3:0] S_EXECUTE = 4'b0110;
    localparam logic [3:0] S_DONE    = 4'b1000;
    localparam logic [3:0] S_SELECT  = 4'b1001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    warp_scheduler_if #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW), .WID_W(WW)) bus ();

    warp_scheduler #(.NUM_WARPS(NW), .THREADS_PER_WARP(TPW), .WID_W(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_upd_cyc = 0;
    int n_upd = 0;
    int icnt [NW];
    int exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Warp order scoreboard; also plays the decoder: each warp's 2nd instruction is RET.
    initial begin
        bus.decoded_ret = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && bus.update_en) begin
                n_upd++;
                last_upd_cyc = cyc;
                if (exp_q.size() == 0)
                    chk("unexpected_update", {30'd0, bus.active_warp}, 32'hFF);
                else
                    chk("warp_order", {30'd0, bus.active_warp}, exp_q.pop_front());
                bus.decoded_ret = (icnt[bus.active_warp] >= 1);
                icnt[bus.active_warp]++;
            end else begin
                bus.decoded_ret = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NW; i++) icnt[i] = 0;
        n_upd = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.num_warps = '0;
        bus.request_ready = 1'b1;
        bus.lsu_state = '0;
        step();
        step();
        clear_model();
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, {28'd0, bus.core_state}, {28'd0, S_IDLE});
        chk({tag, "_aw"}, {30'd0, bus.active_warp}, 32'd0);
        chk({tag, "_wdone"}, {28'd0, bus.warp_done}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_wait"}, {16'd0, bus.wait_cycles}, 32'd0);
        chk({tag, "_upd"}, {31'd0, bus.update_en}, 32'd0);
    endtask

    task automatic launch(input int n);
        logic [31:0] nv;
        nv = n;
        bus.num_warps = nv[WW:0];
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && bus.done !== 1'b1; i++) step();
        chk(tag, {31'd0, bus.done}, 32'd1);
    endtask

    task automatic push_seq(input int n, input int reps);
        for (int r = 0; r < reps; r++)
            for (int w = 0; w < n; w++) exp_q.push_back(w);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.num_warps = '0;
        bus.request_ready = 1'b1;
        bus.lsu_state = '0;
        do_reset();
        check_reset_vals("rst0");

        // Three warps interleaved, each retiring on its second instruction.
        push_seq(3, 2);
        launch(3);
        chk("t1_select", {28'd0, bus.core_state}, {28'd0, S_SELECT});
        wait_done(300, "t1_done");
        chk("t1_wdone", {28'd0, bus.warp_done}, 32'h7);
        chk("t1_qempty", exp_q.size(), 0);
        chk("t1_nupd", n_upd, 6);
        chk("t1_done_lat", cyc - last_upd_cyc, 2);
        chk("t1_waitcyc", {16'd0, bus.wait_cycles}, 32'd6);
        // start in DONE is ignored
        bus.num_warps = 3'd1;
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        chk("t1_hold_state", {28'd0, bus.core_state}, {28'd0, S_DONE});
        chk("t1_hold_done", {31'd0, bus.done}, 32'd1);
        chk("t1_hold_wdone", {28'd0, bus.warp_done}, 32'h7);

        // Zero warps: straight through SELECT to DONE.
        do_reset();
        launch(0);
        chk("t2_select", {28'd0, bus.core_state}, {28'd0, S_SELECT});
        chk("t2_done_early", {31'd0, bus.done}, 32'd0);
        step();
        chk("t2_state", {28'd0, bus.core_state}, {28'd0, S_DONE});
        chk("t2_done", {31'd0, bus.done}, 32'd1);
        step();
        chk("t2_nupd", n_upd, 0);

        // Thread 2 WAITING for 5 WAIT cycles; thread 1 at 11 must not stall.
        do_reset();
        push_seq(1, 2);
        launch(1);
        for (int i = 0; i < 20 && bus.core_state !== S_REQUEST; i++) step();
        chk("t3_req", {28'd0, bus.core_state}, {28'd0, S_REQUEST});
        bus.lsu_state = 8'b00_10_11_00;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_in_wait", {28'd0, bus.core_state}, {28'd0, S_WAIT});
        end
        chk("t3_wait_mid", {16'd0, bus.wait_cycles}, 32'd5);
        bus.lsu_state = '0;
        step();
        chk("t3_exec", {28'd0, bus.core_state}, {28'd0, S_EXECUTE});
        chk("t3_waitcyc", {16'd0, bus.wait_cycles}, 32'd6);
        wait_done(200, "t3_done");
        chk("t3_wdone", {28'd0, bus.warp_done}, 32'h1);

        // Fetch stall, with a stray start carrying a different count.
        do_reset();
        push_seq(2, 2);
        bus.request_ready = 1'b0;
        launch(2);
        step();
        chk("t4_fetch0", {28'd0, bus.core_state}, {28'd0, S_FETCH});
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.num_warps = 3'd4;
                bus.start = 1'b1;
            end
            if (i == 4) bus.start = 1'b0;
            step();
            chk("t4_fetch_hold", {28'd0, bus.core_state}, {28'd0, S_FETCH});
        end
        bus.request_ready = 1'b1;
        wait_done(300, "t4_done");
        chk("t4_wdone", {28'd0, bus.warp_done}, 32'h3);
        chk("t4_nupd", n_upd, 4);

        // Count above NUM_WARPS clamps.
        do_reset();
        push_seq(4, 2);
        launch(7);
        wait_done(400, "t5_done");
        chk("t5_wdone", {28'd0, bus.warp_done}, 32'hF);
        chk("t5_nupd", n_upd, 8);

        // Reset in EXECUTE after warp 1 retired, then relaunch with two warps.
        do_reset();
        push_seq(3, 1);
        exp_q.push_back(0);
        exp_q.push_back(1);
        launch(3);
        for (int i = 0; i < 300 && !(bus.warp_done[1] === 1'b1 && bus.core_state === S_EXECUTE); i++)
            step();
        chk("t6_exec", {28'd0, bus.core_state}, {28'd0, S_EXECUTE});
        chk("t6_w1done", {31'd0, bus.warp_done[1]}, 32'd1);
        chk("t6_qempty", exp_q.size(), 0);
        reset = 1'b1;
        step();
        check_reset_vals("t6_rst");
        reset = 1'b0;
        clear_model();
        push_seq(2, 2);
        launch(2);
        wait_done(300, "t6_done");
        chk("t6_wdone", {28'd0, bus.warp_done}, 32'h3);
        chk("t6_nupd", n_upd, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
